// File: rtl/fir_stream_ctrl_if.sv
// rtl/fir_stream_ctrl_if.sv - sample input stream and framed output stream of fir_stream_ctrl
interface fir_stream_ctrl_if;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               in_last;
  logic               in_ready;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               out_first;
  logic               out_last;
  logic               out_short;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready,
    input  out_valid, out_data, out_first, out_last, out_short
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready,
    output out_valid, out_data, out_first, out_last, out_short
  );
endinterface

// File: rtl/fir_stream_ctrl.sv
// rtl/fir_stream_ctrl.sv - sequencer feeding a non-stallable FIR, aligning results and framing them
module fir_stream_ctrl #(
  parameter int FIR_LAT   = 33,
  parameter int SKIP      = 31,
  parameter int FRAME_LEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  fir_stream_ctrl_if.slave   s,
  output logic               fir_data_valid,
  output logic signed [15:0] fir_data,
  input  logic signed [15:0] fir_d,
  output logic               busy,
  output logic               err_underrun
);

  localparam int FLW = $clog2(FIR_LAT + 1);
  localparam int RW  = $clog2(SKIP + 1) + 1;
  localparam int FCW = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               in_ready;
  logic               accept;
  logic [FLW-1:0]     flush_cnt;
  logic               tag_cur;
  logic               last_cur;
  logic [FIR_LAT-1:0] tag_line;
  logic [FIR_LAT-1:0] last_line;
  logic [RW-1:0]      r_cnt;
  logic [FCW-1:0]     frame_cnt;
  logic               emerge;
  logic               emerge_last;
  logic               frame_end;

  assign s.in_ready   = in_ready;
  assign accept       = in_ready & s.in_valid;
  assign emerge       = tag_line[FIR_LAT-1];
  assign emerge_last  = last_line[FIR_LAT-1];
  assign frame_end    = (frame_cnt == FCW'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    in_ready       = 1'b0;
    fir_data_valid = 1'b0;
    busy           = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        in_ready       = 1'b1;
        fir_data_valid = 1'b1;
        if (s.in_valid && s.in_last) state_nxt = FLUSH;
      end
      FLUSH: begin
        fir_data_valid = 1'b1;
        if (flush_cnt == FLW'(FIR_LAT - 1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fir_data     <= '0;
      tag_cur      <= 1'b0;
      last_cur     <= 1'b0;
      tag_line     <= '0;
      last_line    <= '0;
      flush_cnt    <= '0;
      r_cnt        <= '0;
      frame_cnt    <= '0;
      err_underrun <= 1'b0;
      s.out_valid  <= 1'b0;
      s.out_data   <= '0;
      s.out_first  <= 1'b0;
      s.out_last   <= 1'b0;
      s.out_short  <= 1'b0;
    end else begin
      s.out_valid <= 1'b0;
      s.out_first <= 1'b0;
      s.out_last  <= 1'b0;
      s.out_short <= 1'b0;

      flush_cnt <= (state == FLUSH) ? flush_cnt + FLW'(1) : '0;

      if (state == IDLE && start) begin
        err_underrun <= 1'b0;
        r_cnt        <= '0;
        frame_cnt    <= '0;
      end

      // A gap still feeds the filter (zero sample) so it never sees a stall
      if (accept) begin
        fir_data <= s.in_data;
        tag_cur  <= 1'b1;
        last_cur <= s.in_last;
      end else begin
        fir_data <= '0;
        tag_cur  <= 1'b0;
        last_cur <= 1'b0;
        if (state == RUN) err_underrun <= 1'b1;
      end

      // The line advances in lockstep with the filter and is wiped when the filter is
      if (fir_data_valid) begin
        tag_line  <= {tag_line[FIR_LAT-2:0], tag_cur};
        last_line <= {last_line[FIR_LAT-2:0], last_cur};
      end else begin
        tag_line  <= '0;
        last_line <= '0;
      end

      if (emerge) begin
        if (r_cnt == RW'(SKIP)) begin
          s.out_valid <= 1'b1;
          s.out_data  <= fir_d;
          s.out_first <= (frame_cnt == '0);
          s.out_last  <= frame_end | emerge_last;
          s.out_short <= emerge_last & ~frame_end;
          frame_cnt   <= emerge_last ? '0 : frame_cnt + FCW'(1);
        end else begin
          r_cnt <= r_cnt + RW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb/tb_fir_stream_ctrl.sv - scoreboard bench driving two controllers (SKIP=0 and SKIP=31)
module tb_fir_stream_ctrl;
  localparam int FIR_LAT   = 33;
  localparam int FRAME_LEN = 32;
  localparam int SKIP_B    = 31;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic signed [15:0] in_data = '0;

  always #5 clk = ~clk;

  fir_stream_ctrl_if ia();
  fir_stream_ctrl_if ib();

  assign ia.in_valid = in_valid;
  assign ia.in_data  = in_data;
  assign ia.in_last  = in_last;
  assign ib.in_valid = in_valid;
  assign ib.in_data  = in_data;
  assign ib.in_last  = in_last;

  logic               fdv_a, fdv_b, busy_a, busy_b, err_a, err_b;
  logic signed [15:0] fdat_a, fdat_b, fd_a, fd_b;

  fir_stream_ctrl #(.FIR_LAT(FIR_LAT), .SKIP(0), .FRAME_LEN(FRAME_LEN)) u_a (
    .clk(clk), .rst(rst), .start(start), .s(ia),
    .fir_data_valid(fdv_a), .fir_data(fdat_a), .fir_d(fd_a),
    .busy(busy_a), .err_underrun(err_a)
  );

  fir_stream_ctrl #(.FIR_LAT(FIR_LAT), .SKIP(SKIP_B), .FRAME_LEN(FRAME_LEN)) u_b (
    .clk(clk), .rst(rst), .start(start), .s(ib),
    .fir_data_valid(fdv_b), .fir_data(fdat_b), .fir_d(fd_b),
    .busy(busy_b), .err_underrun(err_b)
  );

  // Identity FIR: pure FIR_LAT delay, cleared whenever data_valid is low
  logic signed [15:0] sr_a [FIR_LAT];
  logic signed [15:0] sr_b [FIR_LAT];

  always @(posedge clk) begin
    for (int i = 0; i < FIR_LAT; i++) begin
      sr_a[i] <= !fdv_a ? 16'sd0 : (i == 0 ? fdat_a : sr_a[(i == 0) ? 0 : i-1]);
      sr_b[i] <= !fdv_b ? 16'sd0 : (i == 0 ? fdat_b : sr_b[(i == 0) ? 0 : i-1]);
    end
  end
  assign fd_a = sr_a[FIR_LAT-1];
  assign fd_b = sr_b[FIR_LAT-1];

  typedef struct {
    logic signed [15:0] d;
    logic [2:0]         flags;
    int                 t;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ka = 0, fca = 0, fcb = 0;
  int   last_acc = 0;
  int   low_run = 0;
  bit   gap_prev = 1'b0;
  bit   busy_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t make_exp(input int fc, input logic signed [15:0] d, input bit last, input int t);
    exp_t e;
    e.d     = d;
    e.flags = {fc == 0, (fc == FRAME_LEN-1) || last, last && (fc != FRAME_LEN-1)};
    e.t     = t;
    return e;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (ia.out_valid) begin
        if (qa.size() == 0) chk("a_unexpected_out", 1, 0);
        else begin
          ea = qa.pop_front();
          chk("a_data", ia.out_data, ea.d);
          chk("a_flags_fls", {ia.out_first, ia.out_last, ia.out_short}, ea.flags);
          chk("a_latency", cyc, ea.t);
        end
      end
      if (ib.out_valid) begin
        if (qb.size() == 0) chk("b_unexpected_out", 1, 0);
        else begin
          eb = qb.pop_front();
          chk("b_data", ib.out_data, eb.d);
          chk("b_flags_fls", {ib.out_first, ib.out_last, ib.out_short}, eb.flags);
          chk("b_latency", cyc, eb.t);
        end
      end
      if (gap_prev) begin
        chk("gap_fir_data_zero", fdat_a, 0);
        chk("gap_fir_valid_held", fdv_a, 1);
      end
      gap_prev = ia.in_ready && !in_valid;
      if (busy_a && !fdv_a) low_run++;
      if (busy_prev && !busy_a && rst) begin
        chk("done_valid_low_cycles", low_run, 1);
        chk("busy_drop_latency", cyc - last_acc, FIR_LAT + 2);
      end
      if (!busy_a) low_run = 0;
      busy_prev = busy_a;
      if (start && !busy_a) begin
        ka = 0; fca = 0; fcb = 0;
      end
      if (in_valid && ia.in_ready) begin
        qa.push_back(make_exp(fca, in_data, in_last, cyc + FIR_LAT + 2));
        fca = in_last ? 0 : (fca + 1) % FRAME_LEN;
        if (ka >= SKIP_B) begin
          qb.push_back(make_exp(fcb, in_data, in_last, cyc + FIR_LAT + 2));
          fcb = in_last ? 0 : (fcb + 1) % FRAME_LEN;
        end
        ka++;
        last_acc = cyc;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy_a; i++) @(posedge clk);
    chk("idle_timeout", busy_a, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int base, input int gap_at, input bit mid_start, input bit do_wait);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        in_last  = 1'b1;
        repeat (3) @(posedge clk);
        #1 in_last = 1'b0;
      end
      if (mid_start && i == n / 2) start = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'(base + i);
      in_last  = (i == n - 1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (do_wait) wait_idle();
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_out_flags", {ia.out_first, ia.out_last, ia.out_short}, 0);
    chk("rst_out_data", ia.out_data, 0);
    chk("rst_in_ready", ia.in_ready, 0);
    chk("rst_fir_valid", fdv_a, 0);
    chk("rst_fir_data", fdat_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_err", err_a, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run(64, 0, -1, 1'b0, 1'b1);
    chk("clean_err_a", err_a, 0);
    run(95, -500, -1, 1'b0, 1'b1);
    run(40, 1000, -1, 1'b0, 1'b1);
    run(50, -20, 20, 1'b1, 1'b1);
    chk("underrun_sticky_a", err_a, 1);
    chk("underrun_sticky_b", err_b, 1);
    run(10, 7, -1, 1'b0, 1'b1);
    chk("err_cleared_at_start", err_a, 0);

    run(40, 300, -1, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_out_valid", ia.out_valid, 0);
    chk("async_rst_busy", busy_a, 0);
    chk("async_rst_fir_valid", fdv_a, 0);
    chk("async_rst_fir_data", fdat_a, 0);
    chk("async_rst_out_data", ia.out_data, 0);
    qa.delete();
    qb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    run(40, -3000, -1, 1'b0, 1'b1);
    chk("post_reset_err", err_a, 0);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
